c2c_master_burst_ctrl: RTL
==========================

// Module: c2c_master_burst_ctrl
// PURPOSE
//  Next-generation chip2chip master control. Width- and burst-parametrised: moves 1..BURST_MAX words of DATA_W bits per transaction.
//  Handshake: request/ack, then a timed notice phase, then a 4-phase valid/ack exchange per word.
//  Adds ack timeout, bounded retry and error reporting. Sits between the user-side word source (buttons/switches or FIFO) and the board-to-board pins.
// PARAMETERS
//  DATA_W       3            data bus width, bits
//  BURST_MAX    4            max words per transaction (>=1)
//  NOTICE_CYC   100_000_000  cycles notice is held after ack (1 s @ 100 MHz)
//  ACK_TIMEOUT  1_000_000    cycles to wait for any ack edge before timeout
//  MAX_RETRY    3            request retries before err; 0 = no retry
// PORTS
//  clk        in   1                      clock
//  rst_n      in   1                      synchronous, active-low reset
//  request    in   1                      user start (level; sampled only in IDLE)
//  burst_len  in   $clog2(BURST_MAX+1)    words to send; sampled with request
//  data_in    in   DATA_W                 current user word
//  data_rd    out  1                      1-cycle pulse: data_in consumed, present next word
//  ack        in   1                      slave ack (pre-synchronised)
//  request2s  out  1                      request to slave
//  notice     out  1                      ack-received indicator (LED)
//  data       out  DATA_W                 word to slave, registered
//  valid      out  1                      data valid to slave
//  busy       out  1                      high in every state except IDLE
//  err        out  1                      1-cycle pulse on retry exhaustion or mid-burst timeout
// BEHAVIOUR
//  All outputs registered. Reset: state=IDLE; request2s, notice, valid, data_rd, err = 0; data = 0; counters = 0.
//  Reset mid-operation aborts at the next edge; no partial-word recovery.
//  IDLE:   request=1 and burst_len!=0 -> REQ, latch len=min(burst_len,BURST_MAX), request2s=1 next cycle.
//          burst_len=0 -> request ignored.
//  REQ:    request2s=1, timer runs.
//          ack=1 -> NOTICE, request2s=0, timer reloads.
//          Timer hits ACK_TIMEOUT:
//            retries<MAX_RETRY -> DROP (request2s=0 for exactly 1 cycle), retries++, back to REQ.
//            otherwise -> err pulse, IDLE.
//  NOTICE: notice=1 for exactly NOTICE_CYC cycles, then -> SEND with data<=data_in, valid=1, data_rd pulse, same edge.
//  SEND:   hold data/valid until ack=0 (slave consumed); then valid=0, word_cnt++.
//          word_cnt==len -> IDLE (busy=0 next cycle); else -> GAP.
//  GAP:    valid=0, wait ack=1 (slave ready), then -> SEND with next word + data_rd pulse.
//  SEND/GAP waits exceeding ACK_TIMEOUT -> err pulse, valid=0, data=0, IDLE.
//  ack already 1 on REQ entry: REQ lasts one cycle.
//  request held high across a completed transaction starts a new one from IDLE.
//  Counter widths: $clog2 of each bound. word_cnt saturates at BURST_MAX; no wrap.
//  Latency: request -> request2s 1 cycle; ack -> notice 1 cycle; notice end -> valid 1 cycle.
// STRUCTURE
//  Package c2c_pkg: state encoding (IDLE, REQ, DROP, NOTICE, SEND, GAP), clog2-width localparams.
//  Sub-module c2c_timer: load/enable down-counter with done flag.
//    One instance, shared by the timeout and notice phases; reloaded on every state change.
// TESTING  (DATA_W=8, BURST_MAX=4, NOTICE_CYC=4, ACK_TIMEOUT=8, MAX_RETRY=2)
//  1. request=1, len=1, ack rises 3 cyc later -> notice high 4 cyc, valid with data=0xA5.
//     ack=0 -> valid=0, busy=0.
//  2. len=3, words 0x11,0x22,0x33, slave toggles ack -> 3 data_rd pulses, words in order, valid low in each GAP.
//  3. ack never rises -> request2s high 8 cyc, 1-cyc drop, x2 retries, then err pulse, IDLE.
//  4. len=7 -> clamped to 4 words. len=0 -> busy stays 0.
//  5. rst_n=0 during SEND of word 2 -> next edge all outputs 0, IDLE.
//     New request afterwards completes normally.
//  6. Slave stalls in GAP >8 cyc -> err pulse, valid=0, IDLE.

Source files
------------

// File: rtl/c2c_pkg.sv
// -----------------------------------------------------------------------------
// c2c_pkg
// Shared definitions for the chip2chip burst master:
//   - state_t : controller state encoding
//   - cnt_w() : width of a counter that must hold values 0..n-1 (never below 1)
// -----------------------------------------------------------------------------
package c2c_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_REQ    = 3'd1,
    ST_DROP   = 3'd2,
    ST_NOTICE = 3'd3,
    ST_SEND   = 3'd4,
    ST_GAP    = 3'd5
  } state_t;

  localparam int STATE_W = 3;

  // A bound of 0 or 1 would give a zero-width vector, so clamp to one bit.
  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/c2c_timer.sv
// -----------------------------------------------------------------------------
// c2c_timer
// Loadable down-counter with a terminal flag. Loading N-1 makes done assert
// on the N-th cycle after the load, so a state that leaves on done lasts
// exactly N cycles.
// Ports:
//   clk, rst_n : clock, synchronous active-low reset
//   load       : load load_val (takes priority over counting)
//   load_val   : reload value
//   en         : count down by one per cycle while non-zero
//   done       : counter is at zero
// -----------------------------------------------------------------------------
module c2c_timer
  import c2c_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         done
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - W'(1);
    end
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/c2c_master_burst_ctrl.sv
// -----------------------------------------------------------------------------
// c2c_master_burst_ctrl
// Chip2chip master: request/ack handshake, timed notice phase, then a
// valid/ack exchange per word for 1..BURST_MAX words. Ack timeouts cause
// bounded request retries; exhaustion or a mid-burst stall raises err.
// Ports:
//   clk, rst_n : clock, synchronous active-low reset
//   request    : user start level, sampled only in IDLE
//   burst_len  : words to send, sampled with request (clamped to BURST_MAX)
//   data_in    : current user word
//   data_rd    : 1-cycle pulse, data_in was captured, present the next word
//   ack        : slave ack (already synchronised)
//   request2s  : request to slave
//   notice     : ack-received indicator
//   data       : registered word to slave
//   valid      : data valid to slave
//   busy       : controller not idle
//   err        : 1-cycle pulse on retry exhaustion or mid-burst timeout
// -----------------------------------------------------------------------------
module c2c_master_burst_ctrl
  import c2c_pkg::*;
#(
  parameter int DATA_W      = 3,
  parameter int BURST_MAX   = 4,
  parameter int NOTICE_CYC  = 100_000_000,
  parameter int ACK_TIMEOUT = 1_000_000,
  parameter int MAX_RETRY   = 3
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           request,
  input  logic [$clog2(BURST_MAX+1)-1:0] burst_len,
  input  logic [DATA_W-1:0]              data_in,
  output logic                           data_rd,
  input  logic                           ack,
  output logic                           request2s,
  output logic                           notice,
  output logic [DATA_W-1:0]              data,
  output logic                           valid,
  output logic                           busy,
  output logic                           err
);

  localparam int LEN_W = $clog2(BURST_MAX + 1);
  localparam int RTY_W = cnt_w(MAX_RETRY + 1);
  localparam int TMR_W = cnt_w((NOTICE_CYC > ACK_TIMEOUT) ? NOTICE_CYC : ACK_TIMEOUT);

  localparam logic [LEN_W-1:0] LEN_MAX      = LEN_W'(BURST_MAX);
  localparam logic [RTY_W-1:0] RTY_MAX      = RTY_W'(MAX_RETRY);
  localparam logic [TMR_W-1:0] NOTICE_LOAD  = TMR_W'(NOTICE_CYC - 1);
  localparam logic [TMR_W-1:0] TIMEOUT_LOAD = TMR_W'(ACK_TIMEOUT - 1);

  state_t             state;
  state_t             state_nxt;
  logic [LEN_W-1:0]   len;
  logic [LEN_W-1:0]   word_cnt;
  logic [LEN_W:0]     cnt_inc;
  logic               last_word;
  logic [RTY_W-1:0]   retries;
  logic               fail;

  logic               t_load;
  logic [TMR_W-1:0]   t_val;
  logic               t_done;

  logic               request2s_nxt;
  logic               notice_nxt;
  logic               valid_nxt;
  logic               busy_nxt;
  logic               err_nxt;
  logic               data_rd_nxt;
  logic [DATA_W-1:0]  data_nxt;

  // One timer serves every phase: it restarts whenever the state changes,
  // with the notice length for NOTICE and the ack timeout for everything else.
  assign t_load = (state_nxt != state);
  assign t_val  = (state_nxt == ST_NOTICE) ? NOTICE_LOAD : TIMEOUT_LOAD;

  c2c_timer #(
    .W (TMR_W)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (t_load),
    .load_val (t_val),
    .en       (state != ST_IDLE),
    .done     (t_done)
  );

  // The word being acknowledged now is the last one when count+1 reaches len.
  assign cnt_inc   = {1'b0, word_cnt} + {{LEN_W{1'b0}}, 1'b1};
  assign last_word = (cnt_inc >= {1'b0, len});

  // State register, transaction counters and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      len       <= '0;
      word_cnt  <= '0;
      retries   <= '0;
      request2s <= 1'b0;
      notice    <= 1'b0;
      valid     <= 1'b0;
      busy      <= 1'b0;
      err       <= 1'b0;
      data_rd   <= 1'b0;
      data      <= '0;
    end else begin
      state     <= state_nxt;
      request2s <= request2s_nxt;
      notice    <= notice_nxt;
      valid     <= valid_nxt;
      busy      <= busy_nxt;
      err       <= err_nxt;
      data_rd   <= data_rd_nxt;
      data      <= data_nxt;

      if ((state == ST_IDLE) && (state_nxt == ST_REQ)) begin
        len      <= (burst_len > LEN_MAX) ? LEN_MAX : burst_len;
        word_cnt <= '0;
        retries  <= '0;
      end

      if ((state == ST_REQ) && (state_nxt == ST_DROP)) begin
        retries <= retries + RTY_W'(1);
      end

      // ack falling in SEND means the slave took the word; never count past BURST_MAX.
      if ((state == ST_SEND) && !ack && (word_cnt != LEN_MAX)) begin
        word_cnt <= word_cnt + LEN_W'(1);
      end
    end
  end

  // Next-state logic. In REQ/SEND/GAP an ack edge wins over a timeout that
  // expires in the same cycle.
  always_comb begin
    state_nxt = state;
    fail      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (request && (burst_len != '0)) begin
          state_nxt = ST_REQ;
        end
      end
      ST_REQ: begin
        if (ack) begin
          state_nxt = ST_NOTICE;
        end else if (t_done) begin
          if (retries < RTY_MAX) begin
            state_nxt = ST_DROP;
          end else begin
            state_nxt = ST_IDLE;
            fail      = 1'b1;
          end
        end
      end
      ST_DROP: begin
        state_nxt = ST_REQ;
      end
      ST_NOTICE: begin
        if (t_done) begin
          state_nxt = ST_SEND;
        end
      end
      ST_SEND: begin
        if (!ack) begin
          state_nxt = last_word ? ST_IDLE : ST_GAP;
        end else if (t_done) begin
          state_nxt = ST_IDLE;
          fail      = 1'b1;
        end
      end
      ST_GAP: begin
        if (ack) begin
          state_nxt = ST_SEND;
        end else if (t_done) begin
          state_nxt = ST_IDLE;
          fail      = 1'b1;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Output logic: next values of the registered outputs, derived from the
  // transition being taken so every output changes on the same edge as state.
  always_comb begin
    request2s_nxt = (state_nxt == ST_REQ);
    notice_nxt    = (state_nxt == ST_NOTICE);
    valid_nxt     = (state_nxt == ST_SEND);
    busy_nxt      = (state_nxt != ST_IDLE);
    err_nxt       = fail;
    data_rd_nxt   = (state_nxt == ST_SEND) && (state != ST_SEND);
    data_nxt      = data;
    if (data_rd_nxt) begin
      data_nxt = data_in;
    end else if (fail) begin
      data_nxt = '0;
    end
  end

endmodule
